// File: rtl/array_search_stream.sv
// Streaming min/max search: LANES elements per beat, one {index, value, count, err} result per frame.
// Optional build macro ARRAY_SEARCH_TIE_LAST_EN makes ties resolve to the last occurrence.

module array_search_lane #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int IWIDTH  = 10,
  parameter int MAX_LEN = 256,
  parameter int LANE    = 0
) (
  input  logic              keep,
  input  logic [DWIDTH-1:0] data,
  input  logic [IWIDTH-1:0] base,
  output logic              v,
  output logic [DWIDTH-1:0] d,
  output logic [AWIDTH-1:0] a
);
  localparam logic [IWIDTH-1:0] LIM = IWIDTH'(MAX_LEN);
  logic [IWIDTH-1:0] idx;

  // Elements at or past MAX_LEN still count but never compete.
  assign idx = base + IWIDTH'(LANE);
  assign v   = keep && (idx < LIM);
  assign d   = data;
  assign a   = idx[AWIDTH-1:0];
endmodule

module array_search_stream #(
  parameter int DWIDTH  = 8,
  parameter int LANES   = 4,
  parameter int MAX_LEN = 256,
  parameter int SIGNED  = 0,
  parameter int AWIDTH  = $clog2(MAX_LEN),
  parameter int CWIDTH  = $clog2(MAX_LEN+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_max,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*DWIDTH-1:0] s_data,
  input  logic [LANES-1:0]        s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [AWIDTH-1:0]       m_addr,
  output logic [DWIDTH-1:0]       m_data,
  output logic [CWIDTH-1:0]       m_count,
  output logic                    m_err
);
  localparam int IWIDTH = CWIDTH + $clog2(LANES+1) + 1;
  localparam int PWIDTH = $clog2(LANES+1);
  localparam int LV     = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int P      = 1 << LV;
  localparam logic [IWIDTH-1:0] LIM = IWIDTH'(MAX_LEN);

  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nxt;

  logic              rdy_q, mode_q, have_q, err_q;
  logic [DWIDTH-1:0] best_q;
  logic [AWIDTH-1:0] idx_q;
  logic [CWIDTH-1:0] cnt_q;

  logic              s_fire, mode_eff, upd;
  logic [PWIDTH-1:0] pop;
  logic [IWIDTH-1:0] base, sum;
  logic [DWIDTH-1:0] nxt_best;
  logic [AWIDTH-1:0] nxt_idx;
  logic [CWIDTH-1:0] nxt_cnt;
  logic              nxt_err;
  logic              wv;
  logic [DWIDTH-1:0] wd;
  logic [AWIDTH-1:0] wa;

  // Strictly-better test: x beats y under the current mode.
  function automatic logic beats(input logic [DWIDTH-1:0] x, input logic [DWIDTH-1:0] y,
                                 input logic mx);
    logic lt, gt;
    if (SIGNED != 0) begin
      lt = $signed(x) < $signed(y);
      gt = $signed(x) > $signed(y);
    end else begin
      lt = x < y;
      gt = x > y;
    end
    return mx ? gt : lt;
  endfunction

  assign s_ready  = rdy_q && (!m_valid || m_ready);
  assign s_fire   = s_valid && s_ready;
  assign mode_eff = (state == IDLE) ? cfg_max : mode_q;
  assign base     = IWIDTH'(cnt_q);

  // Reduction tree over lanes; level 0 holds the leaves, level LV the beat winner.
  genvar l, k;
  for (l = 0; l <= LV; l++) begin : g_lvl
    localparam int N = P >> l;
    logic [N-1:0]             v;
    logic [N-1:0][DWIDTH-1:0] d;
    logic [N-1:0][AWIDTH-1:0] a;
    for (k = 0; k < N; k++) begin : g_node
      if (l == 0) begin : g_leaf
        if (k < LANES) begin : g_lane
          array_search_lane #(
            .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .IWIDTH(IWIDTH),
            .MAX_LEN(MAX_LEN), .LANE(k)
          ) u_lane (
            .keep(s_keep[k]), .data(s_data[k*DWIDTH +: DWIDTH]), .base(base),
            .v(v[k]), .d(d[k]), .a(a[k])
          );
        end else begin : g_pad
          assign v[k] = 1'b0;
          assign d[k] = '0;
          assign a[k] = '0;
        end
      end else begin : g_cmp
        logic pick_hi;
`ifdef ARRAY_SEARCH_TIE_LAST_EN
        assign pick_hi = g_lvl[l-1].v[2*k+1] &&
                         (!g_lvl[l-1].v[2*k] ||
                          !beats(g_lvl[l-1].d[2*k], g_lvl[l-1].d[2*k+1], mode_eff));
`else
        assign pick_hi = g_lvl[l-1].v[2*k+1] &&
                         (!g_lvl[l-1].v[2*k] ||
                          beats(g_lvl[l-1].d[2*k+1], g_lvl[l-1].d[2*k], mode_eff));
`endif
        assign v[k] = g_lvl[l-1].v[2*k] | g_lvl[l-1].v[2*k+1];
        assign d[k] = pick_hi ? g_lvl[l-1].d[2*k+1] : g_lvl[l-1].d[2*k];
        assign a[k] = pick_hi ? g_lvl[l-1].a[2*k+1] : g_lvl[l-1].a[2*k];
      end
    end
  end

  assign wv = g_lvl[LV].v[0];
  assign wd = g_lvl[LV].d[0];
  assign wa = g_lvl[LV].a[0];

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PWIDTH'(s_keep[i]);
  end

  always_comb begin
    upd = 1'b0;
    if (wv) begin
`ifdef ARRAY_SEARCH_TIE_LAST_EN
      upd = !have_q || !beats(best_q, wd, mode_eff);
`else
      upd = !have_q || beats(wd, best_q, mode_eff);
`endif
    end
    sum      = IWIDTH'(cnt_q) + IWIDTH'(pop);
    nxt_best = upd ? wd : best_q;
    nxt_idx  = upd ? wa : idx_q;
    nxt_cnt  = (sum > LIM) ? CWIDTH'(MAX_LEN) : sum[CWIDTH-1:0];
    nxt_err  = err_q | (sum > LIM);
  end

  always_comb begin
    state_nxt = state;
    if (s_fire) state_nxt = s_last ? IDLE : ACC;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // best_q stays zero until the first kept element, so an empty frame reports zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      mode_q  <= 1'b0;
      have_q  <= 1'b0;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      m_count <= '0;
      m_err   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (s_fire) begin
        if (state == IDLE) mode_q <= cfg_max;
        if (s_last) begin
          have_q <= 1'b0;
          best_q <= '0;
          idx_q  <= '0;
          cnt_q  <= '0;
          err_q  <= 1'b0;
        end else begin
          have_q <= have_q | wv;
          best_q <= nxt_best;
          idx_q  <= nxt_idx;
          cnt_q  <= nxt_cnt;
          err_q  <= nxt_err;
        end
      end
      if (s_fire && s_last) begin
        m_valid <= 1'b1;
        m_data  <= nxt_best;
        m_addr  <= nxt_idx;
        m_count <= nxt_cnt;
        m_err   <= nxt_err;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_array_search_stream.sv
// Bench for array_search_stream: unsigned and signed instances share one stimulus stream,
// results checked against a flat element-list reference model.

module tb_array_search_stream;
  localparam int DW = 8, LN = 4, ML = 16, AW = 4, CW = 5, RW = 1 + DW + AW + CW + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_max = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [LN*DW-1:0] s_data = '0;
  logic [LN-1:0]    s_keep = '0;

  logic s_ready_u, m_valid_u, m_err_u, s_ready_s, m_valid_s, m_err_s;
  logic [AW-1:0] m_addr_u, m_addr_s;
  logic [DW-1:0] m_data_u, m_data_s;
  logic [CW-1:0] m_count_u, m_count_s;
  logic [RW-1:0] res_u, res_s;

  always #5 clk = ~clk;

  array_search_stream #(.DWIDTH(DW), .LANES(LN), .MAX_LEN(ML), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .cfg_max(cfg_max), .s_valid(s_valid), .s_ready(s_ready_u),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .m_valid(m_valid_u), .m_ready(m_ready),
    .m_addr(m_addr_u), .m_data(m_data_u), .m_count(m_count_u), .m_err(m_err_u));

  array_search_stream #(.DWIDTH(DW), .LANES(LN), .MAX_LEN(ML), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .cfg_max(cfg_max), .s_valid(s_valid), .s_ready(s_ready_s),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .m_valid(m_valid_s), .m_ready(m_ready),
    .m_addr(m_addr_s), .m_data(m_data_s), .m_count(m_count_s), .m_err(m_err_s));

  assign res_u = {m_valid_u, m_data_u, m_addr_u, m_count_u, m_err_u};
  assign res_s = {m_valid_s, m_data_s, m_addr_s, m_count_s, m_err_s};

  int checks = 0, failures = 0;
  logic [LN*DW-1:0] bdat[16];
  logic [LN-1:0]    bkeep[16];
  logic [DW-1:0]    elems[$];
  logic [RW-1:0]    pu, ps;
  bit               pend = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the frame's elements in arrival order; positions >= ML only count.
  function automatic logic [RW-1:0] model(input bit mx, input bit sg);
    logic [DW-1:0] best, x;
    int ba, n;
    bit have, better;
    best = '0; ba = 0; have = 0; n = elems.size();
    for (int j = 0; j < n && j < ML; j++) begin
      x = elems[j];
      if (sg) better = mx ? ($signed(x) > $signed(best)) : ($signed(x) < $signed(best));
      else    better = mx ? (x > best) : (x < best);
`ifdef ARRAY_SEARCH_TIE_LAST_EN
      if (!have || better || x == best) begin
`else
      if (!have || better) begin
`endif
        best = x; ba = j; have = 1;
      end
    end
    return {1'b1, best, AW'(ba), CW'((n > ML) ? ML : n), 1'((n > ML) ? 1 : 0)};
  endfunction

  task automatic run_frame(input string tag, input bit mx, input int nb, input int hold);
    logic [RW-1:0] eu, es;
    int w;
    elems.delete();
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < LN; i++)
        if (bkeep[b][i]) elems.push_back(bdat[b][i*DW +: DW]);
    eu = model(mx, 0);
    es = model(mx, 1);
    if (pend) begin
      for (int h = 0; h < hold; h++) begin
        m_ready = 1'b0; s_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, "_hold_u"}, 32'(res_u), 32'(pu));
        chk({tag, "_hold_s"}, 32'(res_s), 32'(ps));
        chk({tag, "_hold_srdy"}, 32'({s_ready_u, s_ready_s}), 32'(0));
      end
    end
    for (int b = 0; b < nb; b++) begin
      s_valid = 1'b1; s_data = bdat[b]; s_keep = bkeep[b]; s_last = (b == nb - 1);
      m_ready = 1'b1;
      cfg_max = (b == 0) ? mx : 1'($urandom);
      w = 0; #1;
      while (!s_ready_u && w < 20) begin @(negedge clk); #1; w++; end
      if (w >= 20) chk({tag, "_srdy_timeout"}, 32'(0), 32'(1));
      @(posedge clk); @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      if (b == 0 && nb > 1) chk({tag, "_retire"}, 32'({m_valid_u, m_valid_s}), 32'(0));
      if (b != nb - 1 && $urandom_range(0, 3) == 0) @(negedge clk);
    end
    chk({tag, "_res_u"}, 32'(res_u), 32'(eu));
    chk({tag, "_res_s"}, 32'(res_s), 32'(es));
    pu = eu; ps = es; pend = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nk;
    #1;
    chk("rst_res_u", 32'(res_u), 32'(0));
    chk("rst_res_s", 32'(res_s), 32'(0));
    chk("rst_srdy", 32'({s_ready_u, s_ready_s}), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_srdy", 32'({s_ready_u, s_ready_s}), 32'(3));

    // {3,7,2,9} min
    bdat[0] = {8'd9, 8'd2, 8'd7, 8'd3}; bkeep[0] = 4'hF;
    run_frame("t_min1", 0, 1, 0);
    // max with tie across beats, junk in unkept lanes
    bdat[0] = {8'd0, 8'd5, 8'd5, 8'd1}; bkeep[0] = 4'hF;
    bdat[1] = {8'hAA, 8'hAA, 8'd4, 8'd5}; bkeep[1] = 4'h3;
    run_frame("t_max2", 1, 2, 0);
    // signed vs unsigned min
    bdat[0] = {8'h7F, 8'h80, 8'hFE, 8'h05}; bkeep[0] = 4'hF;
    run_frame("t_sgn", 0, 1, 2);
    // overflow: 16 nines then zeros past MAX_LEN
    for (int b = 0; b < 4; b++) begin bdat[b] = {4{8'd9}}; bkeep[b] = 4'hF; end
    bdat[4] = '0; bkeep[4] = 4'hF;
    run_frame("t_ovf", 0, 5, 1);
    // keep=0 mid-frame beat, then empty frame
    bdat[0] = {8'd1, 8'd2, 8'd3, 8'd4}; bkeep[0] = 4'h7;
    bdat[1] = {4{8'h00}};               bkeep[1] = 4'h0;
    bdat[2] = {8'd0, 8'd0, 8'd9, 8'd8}; bkeep[2] = 4'h1;
    run_frame("t_keep0", 1, 3, 0);
    bdat[0] = {4{8'h33}}; bkeep[0] = 4'h0;
    run_frame("t_empty", 1, 1, 0);
    // long backpressure, then back-to-back first beat
    bdat[0] = {8'd10, 8'd20, 8'd30, 8'd40}; bkeep[0] = 4'hF;
    run_frame("t_bp_a", 1, 1, 0);
    bdat[0] = {8'd6, 8'd6, 8'd6, 8'd6}; bkeep[0] = 4'hF;
    bdat[1] = {8'd1, 8'd0, 8'd0, 8'd0}; bkeep[1] = 4'h8 | 4'h7;
    run_frame("t_bp_b", 0, 2, 5);

    // reset mid-frame after two beats
    s_valid = 1'b1; s_data = {4{8'h00}}; s_keep = 4'hF; s_last = 1'b0; m_ready = 1'b1; cfg_max = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0; rst_n = 1'b0; #1;
    chk("mid_rst_res_u", 32'(res_u), 32'(0));
    chk("mid_rst_srdy", 32'({s_ready_u, s_ready_s}), 32'(0));
    @(negedge clk); rst_n = 1'b1; pend = 0;
    @(negedge clk);
    bdat[0] = {8'd3, 8'd6, 8'd1, 8'd4}; bkeep[0] = 4'hF;
    run_frame("t_after_rst", 0, 1, 0);

    // random frames
    for (int f = 0; f < 150; f++) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        nk = (b == nb - 1 || $urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : 4;
        bkeep[b] = 4'((1 << nk) - 1);
        for (int i = 0; i < LN; i++)
          bdat[b][i*DW +: DW] = (f % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      run_frame("rnd", 1'($urandom), nb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
